gru_gate_mac: RTL and testbench

GRU_GATE_MAC -- requirements
Module: gru_gate_mac

---
 rtl/gru_gate_mac.sv | 196 +++++++++++++++++++
 tb/tb_gru_gate_mac.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gru_gate_mac.sv
// gru_gate_mac
// Computes one GRU gate pre-activation vector with a single shared multiplier:
//     pre[j] = b[j] + sum_k W[j][k]*x[k] + sum_k U[j][k]*h[k]
// All words are signed fixed point with FRAC_BITS fractional bits. Each unit
// takes INPUT_FEATURES+GRU_UNITS+2 cycles (bias load, one product per cycle,
// store); the finished vector is published on o_pre_flat together with a
// one-cycle o_valid pulse.
//
// Ports
//   clk              clock
//   rstn             asynchronous active-low reset
//   i_weights_loaded W/U/b buses valid and static; dropping it aborts a run
//   i_start          request a computation (taken only when idle and loaded)
//   i_x_flat         input vector x, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_h_flat         previous hidden state h
//   i_W_flat         input weights, row-major, element j*INPUT_FEATURES+k
//   i_U_flat         recurrent weights, row-major, element j*GRU_UNITS+k
//   i_b_flat         bias vector
//   o_busy           high while a computation is in progress
//   o_valid          one-cycle pulse: o_pre_flat holds a new result
//   o_abort          one-cycle pulse: the running computation was abandoned
//   o_pre_flat       result vector, held between completed runs
module gru_gate_mac #(
    parameter int DATA_WIDTH     = 32,
    parameter int FRAC_BITS      = 16,
    parameter int INPUT_FEATURES = 3,
    parameter int GRU_UNITS      = 3
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic                                         i_weights_loaded,
    input  logic                                         i_start,
    input  logic [INPUT_FEATURES*DATA_WIDTH-1:0]         i_x_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]              i_h_flat,
    input  logic [GRU_UNITS*INPUT_FEATURES*DATA_WIDTH-1:0] i_W_flat,
    input  logic [GRU_UNITS*GRU_UNITS*DATA_WIDTH-1:0]    i_U_flat,
    input  logic [GRU_UNITS*DATA_WIDTH-1:0]              i_b_flat,
    output logic                                         o_busy,
    output logic                                         o_valid,
    output logic                                         o_abort,
    output logic [GRU_UNITS*DATA_WIDTH-1:0]              o_pre_flat
);

    localparam int DW    = DATA_WIDTH;
    localparam int ACCW  = 2 * DATA_WIDTH + 8;
    localparam int MAC_N = INPUT_FEATURES + GRU_UNITS;
    localparam int KW    = (MAC_N > 1) ? $clog2(MAC_N) : 1;
    localparam int UW    = (GRU_UNITS > 1) ? $clog2(GRU_UNITS) : 1;

    localparam logic [KW-1:0] LAST_K = KW'(MAC_N - 1);
    localparam logic [UW-1:0] LAST_U = UW'(GRU_UNITS - 1);

    // Saturation limits of a DW-bit signed word, expressed at accumulator width.
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MAC,
        S_STORE,
        S_DONE
    } state_t;

    state_t                          r_state;
    logic [UW-1:0]                   r_unit;
    logic [KW-1:0]                   r_k;
    logic signed [ACCW-1:0]          r_acc;
    logic [INPUT_FEATURES*DW-1:0]    r_x;
    logic [GRU_UNITS*DW-1:0]         r_h;
    logic [GRU_UNITS*DW-1:0]         r_buf;

    logic signed [DW-1:0]            w_a;
    logic signed [DW-1:0]            w_b;
    logic signed [2*DW-1:0]          w_prod;
    logic signed [DW-1:0]            w_bias;
    logic [DW-1:0]                   w_res;
    logic [GRU_UNITS*DW-1:0]         w_buf_next;

    // Drop the fractional bits (floor) and clamp into the signed word range.
    function automatic logic [DW-1:0] sat_shift(input logic signed [ACCW-1:0] acc);
        logic signed [ACCW-1:0] sh;
        sh = acc >>> FRAC_BITS;
        if (sh > SAT_MAX)
            return {1'b0, {(DW-1){1'b1}}};
        else if (sh < SAT_MIN)
            return {1'b1, {(DW-1){1'b0}}};
        else
            return sh[DW-1:0];
    endfunction

    // Operand select: the first INPUT_FEATURES steps use W and x, the rest U and h.
    always_comb begin
        int unit_i;
        int k_i;
        unit_i = int'(r_unit);
        k_i    = int'(r_k);
        w_a    = '0;
        w_b    = '0;
        if (k_i < INPUT_FEATURES) begin
            w_a = i_W_flat[(unit_i*INPUT_FEATURES + k_i)*DW +: DW];
            w_b = r_x[k_i*DW +: DW];
        end else begin
            w_a = i_U_flat[(unit_i*GRU_UNITS + k_i - INPUT_FEATURES)*DW +: DW];
            w_b = r_h[(k_i - INPUT_FEATURES)*DW +: DW];
        end
        w_bias     = i_b_flat[unit_i*DW +: DW];
        w_res      = sat_shift(r_acc);
        w_buf_next = r_buf;
        w_buf_next[unit_i*DW +: DW] = w_res;
    end

    assign w_prod = w_a * w_b;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_unit     <= '0;
            r_k        <= '0;
            r_acc      <= '0;
            r_x        <= '0;
            r_h        <= '0;
            r_buf      <= '0;
            o_busy     <= 1'b0;
            o_valid    <= 1'b0;
            o_abort    <= 1'b0;
            o_pre_flat <= '0;
        end else begin
            o_valid <= 1'b0;
            o_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && i_weights_loaded) begin
                        r_x     <= i_x_flat;
                        r_h     <= i_h_flat;
                        r_unit  <= '0;
                        r_state <= S_INIT;
                        o_busy  <= 1'b1;
                    end
                end
                S_INIT: begin
                    if (!i_weights_loaded) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        o_abort <= 1'b1;
                    end else begin
                        // Bias is aligned to the product scale (2*FRAC_BITS fraction).
                        r_acc   <= $signed({{(DW+8){w_bias[DW-1]}}, w_bias}) <<< FRAC_BITS;
                        r_k     <= '0;
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (!i_weights_loaded) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        o_abort <= 1'b1;
                    end else begin
                        r_acc <= r_acc + $signed({{8{w_prod[2*DW-1]}}, w_prod});
                        if (r_k == LAST_K)
                            r_state <= S_STORE;
                        else
                            r_k <= r_k + 1'b1;
                    end
                end
                S_STORE: begin
                    if (!i_weights_loaded) begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        o_abort <= 1'b1;
                    end else begin
                        r_buf <= w_buf_next;
                        if (r_unit == LAST_U) begin
                            // Publish the whole vector at once, including this unit.
                            o_pre_flat <= w_buf_next;
                            o_valid    <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_unit  <= r_unit + 1'b1;
                            r_state <= S_INIT;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gru_gate_mac.sv
// tb_gru_gate_mac
// Directed bench for gru_gate_mac at default parameters (Q16.16, 3 inputs,
// 3 units). Expected results are hand-computed fixed-point constants.
module tb_gru_gate_mac;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int NU = 3;

    logic                    clk;
    logic                    rstn;
    logic                    i_weights_loaded;
    logic                    i_start;
    logic [NF*DW-1:0]        i_x_flat;
    logic [NU*DW-1:0]        i_h_flat;
    logic [NU*NF*DW-1:0]     i_W_flat;
    logic [NU*NU*DW-1:0]     i_U_flat;
    logic [NU*DW-1:0]        i_b_flat;
    logic                    o_busy;
    logic                    o_valid;
    logic                    o_abort;
    logic [NU*DW-1:0]        o_pre_flat;

    int n_checks = 0;
    int n_errs   = 0;

    gru_gate_mac #(
        .DATA_WIDTH     (DW),
        .FRAC_BITS      (16),
        .INPUT_FEATURES (NF),
        .GRU_UNITS      (NU)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_weights_loaded (i_weights_loaded),
        .i_start          (i_start),
        .i_x_flat         (i_x_flat),
        .i_h_flat         (i_h_flat),
        .i_W_flat         (i_W_flat),
        .i_U_flat         (i_U_flat),
        .i_b_flat         (i_b_flat),
        .o_busy           (o_busy),
        .o_valid          (o_valid),
        .o_abort          (o_abort),
        .o_pre_flat       (o_pre_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] w, input logic [31:0] x, input logic [31:0] u,
                           input logic [31:0] h, input logic [31:0] b);
        for (int i = 0; i < NU*NF; i++) i_W_flat[i*DW +: DW] = w;
        for (int i = 0; i < NU*NU; i++) i_U_flat[i*DW +: DW] = u;
        for (int i = 0; i < NF; i++)    i_x_flat[i*DW +: DW] = x;
        for (int i = 0; i < NU; i++)    i_h_flat[i*DW +: DW] = h;
        for (int i = 0; i < NU; i++)    i_b_flat[i*DW +: DW] = b;
    endtask

    task automatic chk_pre(input string tag, input logic [31:0] exp);
        for (int j = 0; j < NU; j++)
            chk($sformatf("%s[%0d]", tag, j), {32'h0, o_pre_flat[j*DW +: DW]}, {32'h0, exp});
    endtask

    // Accept a start, then count edges until o_valid (-1 if it never comes).
    task automatic run(output int edges);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        edges = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (o_valid) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic run_chk(input string tag, input logic [31:0] exp);
        int e;
        run(e);
        chk({tag, "_lat"}, 64'(e), 64'd24);
        chk_pre(tag, exp);
        tick();
        chk({tag, "_vpulse"}, {63'h0, o_valid}, 64'd0);
        chk({tag, "_idle"}, {63'h0, o_busy}, 64'd0);
    endtask

    initial begin
        int e;
        int nvalid;
        rstn             = 1'b0;
        i_weights_loaded = 1'b1;
        i_start          = 1'b0;
        set_bus(32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        chk("rst_busy",  {63'h0, o_busy},  64'd0);
        chk("rst_valid", {63'h0, o_valid}, 64'd0);
        chk("rst_abort", {63'h0, o_abort}, 64'd0);
        chk("rst_pre",   {32'h0, o_pre_flat[31:0]}, 64'd0);
        rstn = 1'b1;
        tick();

        // 1*1*6 + 0.5 = 6.5
        set_bus(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00008000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("acc_busy", {63'h0, o_busy}, 64'd1);
        e = -1;
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (o_valid) begin
                e = n;
                break;
            end
        end
        chk("ones_lat", 64'(e), 64'd24);
        chk_pre("ones", 32'h00068000);
        tick();
        chk("ones_vpulse", {63'h0, o_valid}, 64'd0);

        // -1 * 2 * 3 = -6
        set_bus(32'hFFFF0000, 32'h00020000, 32'h0, 32'h0, 32'h0);
        run_chk("neg", 32'hFFFA0000);

        // 32767^2 * 3 overflows both ways
        set_bus(32'h7FFF0000, 32'h7FFF0000, 32'h0, 32'h0, 32'h0);
        run_chk("satp", 32'h7FFFFFFF);
        set_bus(32'h80010000, 32'h7FFF0000, 32'h0, 32'h0, 32'h0);
        run_chk("satn", 32'h80000000);

        // Reload a known result, then abort a run at cycle 10.
        set_bus(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00008000);
        run_chk("pre_ab", 32'h00068000);
        set_bus(32'h00020000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        nvalid = 0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (o_valid) nvalid++;
        end
        i_weights_loaded = 1'b0;
        tick();
        chk("ab_pulse", {63'h0, o_abort}, 64'd1);
        chk("ab_busy",  {63'h0, o_busy},  64'd0);
        i_weights_loaded = 1'b1;
        tick();
        chk("ab_width", {63'h0, o_abort}, 64'd0);
        for (int n = 0; n < 30; n++) begin
            tick();
            if (o_valid) nvalid++;
        end
        chk("ab_novalid", 64'(nvalid), 64'd0);
        chk_pre("ab_hold", 32'h00068000);

        // Start ignored when weights are not loaded.
        i_weights_loaded = 1'b0;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("nowt_busy", {63'h0, o_busy}, 64'd0);
        i_weights_loaded = 1'b1;
        tick();

        // Restart while busy and x changed after acceptance: snapshot wins.
        set_bus(32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00008000);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 0; i < NF; i++) i_x_flat[i*DW +: DW] = 32'h0;
        e = -1;
        for (int n = 1; n <= 60; n++) begin
            i_start = (n == 5);
            tick();
            if (o_valid) begin
                e = n;
                break;
            end
        end
        i_start = 1'b0;
        chk("snap_lat", 64'(e), 64'd24);
        chk_pre("snap", 32'h00068000);

        // Async reset mid-run clears outputs without waiting for an edge.
        set_bus(32'h00010000, 32'h00010000, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int n = 1; n <= 11; n++) tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_busy",  {63'h0, o_busy},  64'd0);
        chk("ar_valid", {63'h0, o_valid}, 64'd0);
        chk("ar_pre",   {32'h0, o_pre_flat[31:0]}, 64'd0);
        tick();
        rstn = 1'b1;
        nvalid = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (o_valid || o_busy) nvalid++;
        end
        chk("ar_quiet", 64'(nvalid), 64'd0);
        run_chk("ar_run", 32'h00030000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
